addsub_rr_scheduler: RTL and testbench
======================================

// Module: addsub_rr_scheduler
// PURPOSE
// Shares one add/subtract datapath between N_REQ requesters. Each requester
// issues a single operation: operands A and B plus a subtract flag.
// A round-robin arbiter grants one request at a time and sequences it through
// the datapath. The block returns a registered result, tagged with the
// requester id, over a valid/ready response channel.
// PARAMETERS
// N_REQ   4   number of requesters (2..16)
// WIDTH   8   operand/result width in bits
// IDW     $clog2(N_REQ)   requester-id width (localparam)
// PORTS
// clk        in   1            rising-edge clock
// reset      in   1            synchronous, active-high reset
// req_valid  in   N_REQ        per-requester request valid
// req_ready  out  N_REQ        one-hot grant/accept, combinational in IDLE
// req_a      in   N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
// req_b      in   N_REQ*WIDTH  operand B, same packing
// req_sub    in   N_REQ        1 = A-B, 0 = A+B
// rsp_valid  out  1            result valid
// rsp_ready  in   1            consumer accepts result
// rsp_data   out  WIDTH        result, modulo 2^WIDTH
// rsp_id     out  IDW          index of requester that issued the op
// rsp_ovf    out  1            signed (two's-complement) overflow of the op
// busy       out  1            high in any state other than IDLE
// BEHAVIOUR
// - Reset (synchronous, active-high) forces the following:
//   state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0,
//   rsp_ovf=0, busy=0. Operand registers are cleared to 0.
// - FSM has three states:
//   IDLE -> CALC on grant; CALC -> RESP always; RESP -> IDLE on
//   rsp_valid&&rsp_ready; RESP holds otherwise.
// - IDLE, arbitration:
//   - Winner is the first i with req_valid[i]=1, searching i = rr_ptr,
//     rr_ptr+1, ... mod N_REQ.
//   - req_ready is one-hot on the winner in the same cycle. req_ready is all-zero
//     outside IDLE, and all-zero when no req_valid is set.
//   - A handshake is req_valid[i]&&req_ready[i]. On handshake:
//     - capture A, B, sub and id;
//     - set rr_ptr = (winner+1) mod N_REQ;
//     - go to CALC.
// - CALC: computes sum = A + (B ^ {WIDTH{sub}}) + sub. Registers rsp_data =
//   sum[WIDTH-1:0] and rsp_ovf = (A[msb]==Bx[msb]) && (sum[msb]!=A[msb]),
//   where Bx = B^{WIDTH{sub}}. Carry-out is discarded.
// - RESP: rsp_valid=1. rsp_data, rsp_id and rsp_ovf stay stable until accepted.
// - Latency: handshake in cycle t gives rsp_valid=1 in cycle t+2. If rsp_ready
//   is held high, the next grant is possible at t+3, so the minimum issue
//   interval is 3 cycles.
// - Fairness: with all N_REQ requesters continuously valid, grants rotate
//   0,1,..,N_REQ-1,0. No requester waits more than N_REQ grants.
// - Requesters must hold req_valid and operands stable until granted. A valid
//   that drops before grant is simply skipped; there is no error.
// - Simultaneous events: a new req_valid arriving while in CALC or RESP waits.
//   The response accept and the next grant never occur in the same cycle.
// - Wrap-around: rsp_data wraps modulo 2^WIDTH, e.g. 0xFF+0x01=0x00 and
//   0x00-0x01=0xFF.
// - Reset mid-operation aborts the in-flight op. No response is produced for
//   it, and rr_ptr returns to 0.
// TESTING
// - Single op: req0 A=0x05 B=0x03 sub=0 -> ready[0] in cycle t, then at t+2
//   rsp_valid=1, data=0x08, id=0, ovf=0.
// - Subtract and wrap: req2 A=0x00 B=0x01 sub=1 -> data=0xFF, id=2, ovf=0.
//   A=0x80 B=0x01 sub=1 -> data=0x7F, ovf=1.
// - Overflow on add: A=0x7F B=0x01 sub=0 -> data=0x80, ovf=1.
//   A=0xFF B=0x01 sub=0 -> data=0x00, ovf=0.
// - Round-robin: all 4 requesters held valid with rsp_ready=1 for 12 ops ->
//   ids 0,1,2,3,0,1,2,3,... with grants exactly 3 cycles apart.
// - Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, data and id stay
//   stable, req_ready stays 0 and busy stays 1. One cycle after rsp_ready=1
//   the block is back in IDLE.
// - Reset in CALC -> next cycle rsp_valid=0, busy=0, and no response is
//   produced. A subsequent request from req3 with req1 also valid is granted
//   to req1 first, because rr_ptr=0.

Source files
------------

// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler that shares one add/subtract datapath between N_REQ
// requesters and returns id-tagged results over a valid/ready channel.
module addsub_rr_scheduler #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       i_req_valid,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic [N_REQ*WIDTH-1:0] i_req_a,
  input  logic [N_REQ*WIDTH-1:0] i_req_b,
  input  logic [N_REQ-1:0]       i_req_sub,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [WIDTH-1:0]       o_rsp_data,
  output logic [IDW-1:0]         o_rsp_id,
  output logic                   o_rsp_ovf,
  output logic                   o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic [IDW-1:0]   r_id;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic [IDW-1:0]   r_rsp_id;
  logic             r_rsp_ovf;
  logic             r_busy;

  logic             w_found;
  logic [IDW-1:0]   w_winner;
  logic [IDW-1:0]   w_next_ptr;
  logic [N_REQ-1:0] w_grant;
  logic             w_handshake;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  // (base + off) mod N_REQ without a divider; off never exceeds N_REQ-1.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                              input int unsigned    off);
    int unsigned s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  // NOTE: every combinational output gets a default before the search loop,
  // otherwise a path that leaves it unassigned would infer a latch.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && i_req_valid[rr_index(r_rr_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = rr_index(r_rr_ptr, k);
      end
    end
  end

  assign w_next_ptr  = rr_index(w_winner, 1);
  assign w_grant     = (w_found && (r_state == S_IDLE) && !reset)
                       ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_winner) : '0;
  assign w_handshake = |(w_grant & i_req_valid);

  // Subtraction is A + ~B + 1; overflow when like-signed inputs give an
  // unlike-signed result. The carry out simply falls off the top.
  assign w_bx  = r_b ^ {WIDTH{r_sub}};
  assign w_sum = r_a + w_bx + {{(WIDTH-1){1'b0}}, r_sub};
  assign w_ovf = (r_a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_ovf   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_handshake) begin
            r_a      <= i_req_a[w_winner*WIDTH +: WIDTH];
            r_b      <= i_req_b[w_winner*WIDTH +: WIDTH];
            r_sub    <= i_req_sub[w_winner];
            r_id     <= w_winner;
            r_rr_ptr <= w_next_ptr;
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_rsp_data  <= w_sum;
          r_rsp_ovf   <= w_ovf;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = w_grant;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_ovf   = r_rsp_ovf;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Self-checking bench for addsub_rr_scheduler: directed corner cases plus
// randomized traffic against a cycle-level behavioural reference model.
module tb_addsub_rr_scheduler;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, req_sub;
  logic [N*W-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready, rsp_ovf, busy;
  logic [W-1:0]   rsp_data;
  logic [IDW-1:0] rsp_id;

  always #5 clk = ~clk;

  addsub_rr_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_sub(req_sub),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_id(rsp_id), .o_rsp_ovf(rsp_ovf),
    .o_busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Requester-side pending ops and bench-driven controls.
  bit         p_valid[N];
  logic [W-1:0] p_a[N], p_b[N];
  bit         p_sub[N];
  bit         tb_reset, tb_rsp_ready;

  // Reference model state.
  typedef enum {M_IDLE, M_CALC, M_RESP} mode_t;
  mode_t m_mode;
  int    m_ptr, m_id, m_a, m_b, m_data, m_rid;
  bit    m_sub, m_ovf;
  int    cyc, g_id, g_cyc, g_cnt;

  function automatic int winner();
    for (int k = 0; k < N; k++)
      if (p_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_check();
    int w, sa, sb, sr;
    w = (m_mode == M_IDLE && !tb_reset) ? winner() : -1;
    check("req_ready", req_ready, (w >= 0) ? (64'd1 << w) : 64'd0);
    check("busy", busy, m_mode != M_IDLE);
    check("rsp_valid", rsp_valid, m_mode == M_RESP);
    if (m_mode == M_RESP) begin
      check("rsp_data", rsp_data, m_data);
      check("rsp_id", rsp_id, m_rid);
      check("rsp_ovf", rsp_ovf, m_ovf);
    end
    if (tb_reset) begin
      m_mode = M_IDLE; m_ptr = 0; m_data = 0; m_rid = 0; m_ovf = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (w >= 0) begin
          m_id = w; m_a = p_a[w]; m_b = p_b[w]; m_sub = p_sub[w];
          p_valid[w] = 0;
          m_ptr = (w + 1) % N;
          g_id = w; g_cyc = cyc; g_cnt++;
          m_mode = M_CALC;
        end
        M_CALC: begin
          m_data = (m_sub ? (m_a - m_b) : (m_a + m_b)) & 'hFF;
          sa = (m_a >= 128) ? m_a - 256 : m_a;
          sb = (m_b >= 128) ? m_b - 256 : m_b;
          sr = m_sub ? sa - sb : sa + sb;
          m_ovf = (sr > 127) || (sr < -128);
          m_rid = m_id;
          m_mode = M_RESP;
        end
        default: if (tb_rsp_ready) m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    reset     = tb_reset;
    rsp_ready = tb_rsp_ready;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = p_valid[i];
      req_sub[i]         = p_sub[i];
      req_a[i*W +: W]    = p_a[i];
      req_b[i*W +: W]    = p_b[i];
    end
    @(negedge clk);
    cyc++;
    model_check();
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] corners [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  task automatic new_op(input int i);
    p_valid[i] = 1; p_a[i] = rnd_operand(); p_b[i] = rnd_operand(); p_sub[i] = $urandom_range(0, 1);
  endtask

  task automatic drain();
    int n;
    for (int i = 0; i < N; i++) p_valid[i] = 0;
    tb_rsp_ready = 1;
    n = 0;
    do begin step(); n++; end while (m_mode != M_IDLE && n < 10);
    check("drain_idle", m_mode == M_IDLE, 1);
  endtask

  task automatic do_reset();
    tb_reset = 1; step();
    tb_reset = 0; step();
  endtask

  task automatic run_op(input string tag, input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit sub, input logic [W-1:0] exp_data, input bit exp_ovf);
    int g0, gc, n;
    drain();
    p_valid[id] = 1; p_a[id] = a; p_b[id] = b; p_sub[id] = sub;
    g0 = g_cnt; n = 0;
    do begin step(); n++; end while (g_cnt == g0 && n < 20);
    check({tag, "_granted"}, g_cnt > g0, 1);
    gc = g_cyc; n = 0;
    do begin step(); n++; end while (rsp_valid !== 1'b1 && n < 10);
    check({tag, "_latency"}, cyc - gc, 2);
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_id"}, rsp_id, id);
    check({tag, "_ovf"}, rsp_ovf, exp_ovf);
    step();
  endtask

  initial begin
    int g0, gprev, k, n;
    logic [W-1:0] bp_data;
    for (int i = 0; i < N; i++) begin p_valid[i] = 0; p_a[i] = 0; p_b[i] = 0; p_sub[i] = 0; end
    reset = 1; rsp_ready = 0; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0;
    m_mode = M_IDLE; m_ptr = 0; m_data = 0; m_rid = 0; m_ovf = 0;
    cyc = 0; g_cnt = 0; g_id = 0; g_cyc = 0;
    tb_reset = 1; tb_rsp_ready = 0;
    repeat (2) @(posedge clk);

    // Reset state, with a request pending that must not be granted.
    p_valid[2] = 1;
    step();
    check("rst_data", rsp_data, 0);
    check("rst_id", rsp_id, 0);
    check("rst_ovf", rsp_ovf, 0);
    p_valid[2] = 0;
    tb_reset = 0;
    step();

    run_op("add_5_3",   0, 8'h05, 8'h03, 0, 8'h08, 0);
    run_op("sub_0_1",   2, 8'h00, 8'h01, 1, 8'hFF, 0);
    run_op("sub_80_1",  2, 8'h80, 8'h01, 1, 8'h7F, 1);
    run_op("add_7f_1",  1, 8'h7F, 8'h01, 0, 8'h80, 1);
    run_op("add_ff_1",  3, 8'hFF, 8'h01, 0, 8'h00, 0);

    // Round-robin with all requesters continuously valid.
    drain();
    do_reset();
    tb_rsp_ready = 1;
    for (int i = 0; i < N; i++) new_op(i);
    k = 0; n = 0; gprev = 0;
    while (k < 12 && n < 100) begin
      g0 = g_cnt;
      step(); n++;
      if (g_cnt != g0) begin
        check("rr_id", g_id, k % N);
        if (k > 0) check("rr_gap", g_cyc - gprev, 3);
        gprev = g_cyc; k++;
      end
      for (int i = 0; i < N; i++) if (!p_valid[i]) new_op(i);
    end
    check("rr_count", k, 12);

    // Backpressure: response must hold while others wait.
    drain();
    tb_rsp_ready = 0;
    p_valid[1] = 1; p_a[1] = 8'h10; p_b[1] = 8'h22; p_sub[1] = 0;
    n = 0;
    do begin step(); n++; end while (rsp_valid !== 1'b1 && n < 10);
    p_valid[0] = 1; p_valid[2] = 1; p_valid[3] = 1;
    bp_data = 8'h32;
    repeat (5) begin
      step();
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, bp_data);
      check("bp_id", rsp_id, 1);
      check("bp_ready", req_ready, 0);
      check("bp_busy", busy, 1);
    end
    tb_rsp_ready = 1;
    step();
    step();
    check("bp_back_idle", busy, 0);

    // Reset while in CALC aborts the op and returns the pointer to 0.
    drain();
    p_valid[0] = 1; p_a[0] = 8'h11; p_b[0] = 8'h22; p_sub[0] = 0;
    g0 = g_cnt; n = 0;
    do begin step(); n++; end while (g_cnt == g0 && n < 20);
    tb_reset = 1;
    step();
    check("calc_busy", busy, 1);
    tb_reset = 0;
    step();
    check("rstc_valid", rsp_valid, 0);
    check("rstc_busy", busy, 0);
    p_valid[3] = 1; p_a[3] = 8'h01; p_b[3] = 8'h02; p_sub[3] = 0;
    p_valid[1] = 1; p_a[1] = 8'h03; p_b[1] = 8'h04; p_sub[1] = 1;
    g0 = g_cnt;
    step();
    check("rstc_no_rsp", rsp_valid, 0);
    check("rstc_grant_cnt", g_cnt - g0, 1);
    check("rstc_grant_id", req_ready, 4'b0010);

    // Randomized traffic with drops and random backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_valid[i] && $urandom_range(0, 3) == 0) new_op(i);
        else if (p_valid[i] && $urandom_range(0, 19) == 0) p_valid[i] = 0;
      end
      tb_rsp_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
